// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the data-cache tag path.
package dcache_pkg;

    localparam int unsigned DCACHE_NUM_WORDS             = 256;
    localparam int unsigned DCACHE_TAG_WIDTH             = 20;
    localparam int unsigned DCACHE_TAG_STORE_DATA_WIDTH  = 24;
    localparam int unsigned TAG_STORE_VALID_BIT_POSITION = DCACHE_TAG_WIDTH;

    typedef struct packed {
        logic [DCACHE_TAG_STORE_DATA_WIDTH-DCACHE_TAG_WIDTH-2:0] pad;
        logic                                                    valid;
        logic [DCACHE_TAG_WIDTH-1:0]                             tag;
    } dcache_tag_entry_t;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        FLUSH
    } dcache_tag_ctrl_state_e;

endpackage

// File: rtl/dcache_tag_ctrl.sv
// Sole master of the tag-store port: init/flush invalidation walk, refill tag writes
// and single-cycle-throughput hit/miss lookups.
module dcache_tag_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_WORDS  = DCACHE_NUM_WORDS,
    parameter int unsigned TAG_WIDTH  = DCACHE_TAG_WIDTH,
    parameter int unsigned DATA_WIDTH = DCACHE_TAG_STORE_DATA_WIDTH,
    localparam int unsigned IW        = $clog2(NUM_WORDS),
    localparam int unsigned BW        = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  flush_done_o,

    input  logic                  req_i,
    output logic                  ready_o,
    input  logic [IW-1:0]         index_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    output logic                  rsp_valid_o,
    output logic                  rsp_hit_o,

    input  logic                  wr_req_i,
    output logic                  wr_gnt_o,
    input  logic [IW-1:0]         wr_index_i,
    input  logic [TAG_WIDTH-1:0]  wr_tag_i,
    input  logic                  wr_valid_i,

    output logic                  ts_en_o,
    output logic                  ts_we_o,
    output logic [BW-1:0]         ts_be_o,
    output logic [IW-1:0]         ts_addr_o,
    output logic [DATA_WIDTH-1:0] ts_wdata_o,
    input  logic [DATA_WIDTH-1:0] ts_rdata_i
);

    localparam int unsigned     VALID_POS = TAG_WIDTH;
    localparam logic [IW-1:0]   LAST_IDX  = IW'(NUM_WORDS - 1);

    dcache_tag_ctrl_state_e state_q, state_d;
    logic [IW-1:0]          cnt_q, cnt_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tag_d        = tag_q;
        rsp_valid_d  = 1'b0;
        busy_o       = 1'b0;
        flush_done_o = 1'b0;
        ready_o      = 1'b0;
        wr_gnt_o     = 1'b0;
        ts_en_o      = 1'b0;
        ts_we_o      = 1'b0;
        ts_be_o      = '0;
        ts_addr_o    = '0;
        ts_wdata_o   = '0;

        unique case (state_q)
            INIT, FLUSH: begin
                // Reset parks us in INIT; keep the port quiet until reset is released.
                if (!rst_i) begin
                    busy_o    = 1'b1;
                    ts_en_o   = 1'b1;
                    ts_we_o   = 1'b1;
                    ts_be_o   = '1;
                    ts_addr_o = cnt_q;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        flush_done_o = 1'b1;
                        cnt_d        = '0;
                        state_d      = IDLE;
                    end
                end
            end

            IDLE: begin
                ready_o = !wr_req_i && !flush_i;
                if (flush_i) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else if (wr_req_i) begin
                    wr_gnt_o   = 1'b1;
                    ts_en_o    = 1'b1;
                    ts_we_o    = 1'b1;
                    ts_be_o    = '1;
                    ts_addr_o  = wr_index_i;
                    ts_wdata_o = DATA_WIDTH'({wr_valid_i, wr_tag_i});
                end else if (req_i) begin
                    ts_en_o     = 1'b1;
                    ts_addr_o   = index_i;
                    tag_d       = tag_i;
                    rsp_valid_d = 1'b1;
                end
            end

            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            tag_q       <= tag_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_hit_o   = rsp_valid_q && ts_rdata_i[VALID_POS]
                         && (ts_rdata_i[TAG_WIDTH-1:0] == tag_q);

    // Pad bits of the read word carry no information.
    if (DATA_WIDTH > TAG_WIDTH + 1) begin : gen_pad
        logic unused_pad;
        assign unused_pad = ^ts_rdata_i[DATA_WIDTH-1:VALID_POS+1];
    end

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Bench for dcache_tag_ctrl with a behavioural tag-store SRAM and an index-level reference model.
module tb_dcache_tag_ctrl;

    localparam int NW = 256;
    localparam int TW = 20;
    localparam int DW = 24;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i;
    logic          flush_i, busy_o, flush_done_o;
    logic          req_i, ready_o;
    logic [7:0]    index_i;
    logic [TW-1:0] tag_i;
    logic          rsp_valid_o, rsp_hit_o;
    logic          wr_req_i, wr_gnt_o;
    logic [7:0]    wr_index_i;
    logic [TW-1:0] wr_tag_i;
    logic          wr_valid_i;
    logic          ts_en_o, ts_we_o;
    logic [2:0]    ts_be_o;
    logic [7:0]    ts_addr_o;
    logic [DW-1:0] ts_wdata_o, ts_rdata;

    dcache_tag_ctrl #(
        .NUM_WORDS (NW),
        .TAG_WIDTH (TW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .busy_o      (busy_o),
        .flush_done_o(flush_done_o),
        .req_i       (req_i),
        .ready_o     (ready_o),
        .index_i     (index_i),
        .tag_i       (tag_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_hit_o   (rsp_hit_o),
        .wr_req_i    (wr_req_i),
        .wr_gnt_o    (wr_gnt_o),
        .wr_index_i  (wr_index_i),
        .wr_tag_i    (wr_tag_i),
        .wr_valid_i  (wr_valid_i),
        .ts_en_o     (ts_en_o),
        .ts_we_o     (ts_we_o),
        .ts_be_o     (ts_be_o),
        .ts_addr_o   (ts_addr_o),
        .ts_wdata_o  (ts_wdata_o),
        .ts_rdata_i  (ts_rdata)
    );

    // Tag-store SRAM; powers up with every entry valid and tag == index so a missed walk shows.
    logic [DW-1:0] mem [NW];
    bit            seeded;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < NW; i++) mem[i] <= {4'b0, 1'b1, 20'(i)};
            seeded <= 1'b1;
        end else if (ts_en_o) begin
            if (ts_we_o) begin
                for (int b = 0; b < 3; b++)
                    if (ts_be_o[b]) mem[ts_addr_o][b*8 +: 8] <= ts_wdata_o[b*8 +: 8];
            end else begin
                ts_rdata <= mem[ts_addr_o];
            end
        end
    end

    int            checks, failures, rsp_seen;
    bit            ref_valid [NW];
    logic [TW-1:0] ref_tag   [NW];
    bit            exp_q [$];

    // One IDLE-state cycle; entered and left at posedge+1.
    task automatic step(input bit f, input bit wr, input int widx, input logic [TW-1:0] wtag,
                        input bit wv, input bit rq, input int idx, input logic [TW-1:0] tag);
        bit            exp_ready, exp_gnt, have_exp, exp_hit;
        logic [DW-1:0] exp_wd;
        flush_i = f;   wr_req_i = wr; wr_index_i = 8'(widx); wr_tag_i = wtag; wr_valid_i = wv;
        req_i   = rq;  index_i  = 8'(idx); tag_i = tag;
        @(negedge clk);
        have_exp = (exp_q.size() > 0);
        checks++;
        if (rsp_valid_o !== have_exp) begin
            failures++;
            $display("FAIL rsp_valid: got %b want %b", rsp_valid_o, have_exp);
        end
        if (rsp_valid_o === 1'b1) rsp_seen++;
        if (have_exp) begin
            exp_hit = exp_q.pop_front();
            checks++;
            if (rsp_hit_o !== exp_hit) begin
                failures++;
                $display("FAIL rsp_hit: got %b want %b", rsp_hit_o, exp_hit);
            end
        end
        exp_gnt   = wr && !f;
        exp_ready = !wr && !f;
        checks++;
        if (ready_o !== exp_ready || wr_gnt_o !== exp_gnt || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL handshake: ready=%b gnt=%b busy=%b want ready=%b gnt=%b busy=0",
                     ready_o, wr_gnt_o, busy_o, exp_ready, exp_gnt);
        end
        checks++;
        if (exp_gnt) begin
            exp_wd = {4'b0, wv, wtag};
            if (ts_en_o !== 1'b1 || ts_we_o !== 1'b1 || ts_be_o !== 3'b111
                || ts_addr_o !== 8'(widx) || ts_wdata_o !== exp_wd) begin
                failures++;
                $display("FAIL ts_write: en=%b we=%b be=%b addr=%0d wd=%h want 1 1 111 %0d %h",
                         ts_en_o, ts_we_o, ts_be_o, ts_addr_o, ts_wdata_o, widx, exp_wd);
            end
            ref_valid[widx] = wv;
            ref_tag[widx]   = wtag;
        end else if (rq && exp_ready) begin
            if (ts_en_o !== 1'b1 || ts_we_o !== 1'b0 || ts_addr_o !== 8'(idx)) begin
                failures++;
                $display("FAIL ts_read: en=%b we=%b addr=%0d want 1 0 %0d",
                         ts_en_o, ts_we_o, ts_addr_o, idx);
            end
            exp_q.push_back(ref_valid[idx] && (ref_tag[idx] == tag));
        end else if (ts_en_o !== 1'b0) begin
            failures++;
            $display("FAIL ts_idle: en=%b want 0", ts_en_o);
        end
        @(posedge clk); #1;
        flush_i = 1'b0; wr_req_i = 1'b0; req_i = 1'b0;
    endtask

    task automatic idle();
        step(0, 0, 0, '0, 0, 0, 0, '0);
    endtask

    // Follows a walk already in progress, with held-off traffic and an optional extra flush.
    task automatic run_walk(input string name, input int flush_at);
        int busy_n  = 0;
        int done_n  = 0;
        int done_at = -1;
        bit ended   = 0;
        for (int i = 0; i < 300; i++) begin
            flush_i    = (i == flush_at);
            req_i      = (i < 200) ? 1'($urandom) : 1'b0;
            wr_req_i   = (i < 200) ? 1'($urandom) : 1'b0;
            index_i    = 8'($urandom);
            tag_i      = 20'($urandom);
            wr_index_i = 8'($urandom);
            wr_tag_i   = 20'($urandom);
            wr_valid_i = 1'($urandom);
            @(negedge clk);
            if (busy_o !== 1'b1) begin
                ended = 1;
                break;
            end
            busy_n++;
            if (flush_done_o === 1'b1) begin
                done_n++;
                done_at = i;
            end
            checks++;
            if (ready_o !== 1'b0 || wr_gnt_o !== 1'b0 || ts_we_o !== 1'b1
                || ts_addr_o !== 8'(i) || ts_wdata_o !== '0) begin
                failures++;
                $display("FAIL %s cycle %0d: ready=%b gnt=%b we=%b addr=%0d wd=%h want 0 0 1 %0d 0",
                         name, i, ready_o, wr_gnt_o, ts_we_o, ts_addr_o, ts_wdata_o, 8'(i));
            end
            @(posedge clk); #1;
        end
        flush_i = 1'b0; req_i = 1'b0; wr_req_i = 1'b0;
        if (ended) begin
            @(posedge clk); #1;
        end
        checks++;
        if (!ended || busy_n != NW) begin
            failures++;
            $display("FAIL %s busy_cycles: got %0d (ended=%b) want %0d", name, busy_n, ended, NW);
        end
        checks++;
        if (done_n != 1 || done_at != NW - 1) begin
            failures++;
            $display("FAIL %s flush_done: pulses=%0d at=%0d want 1 at %0d",
                     name, done_n, done_at, NW - 1);
        end
        for (int i = 0; i < NW; i++) ref_valid[i] = 0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0; req_i = 1'b1; wr_req_i = 1'b1;
        index_i = '0; tag_i = '0; wr_index_i = '0; wr_tag_i = '0; wr_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy_o, flush_done_o, ready_o, rsp_valid_o, rsp_hit_o, wr_gnt_o, ts_en_o, ts_we_o}
            !== 8'b0 || ts_be_o !== 3'b0 || ts_addr_o !== 8'b0 || ts_wdata_o !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b ready=%b rv=%b gnt=%b en=%b want all 0",
                     busy_o, flush_done_o, ready_o, rsp_valid_o, wr_gnt_o, ts_en_o);
        end
        req_i = 1'b0; wr_req_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_init_walk();
        run_walk("init_walk", -1);
        for (int i = 0; i < NW; i++) step(0, 0, 0, '0, 0, 1, i, 20'(i));
        idle();
    endtask

    task automatic test_write_hit();
        step(0, 1, 5, 20'h1A2, 1, 0, 0, '0);
        step(0, 0, 0, '0, 0, 1, 5, 20'h1A2);
        step(0, 0, 0, '0, 0, 1, 5, 20'h1A3);
        step(0, 1, 5, 20'h1A2, 0, 0, 0, '0);
        step(0, 0, 0, '0, 0, 1, 5, 20'h1A2);
        // Write right behind a lookup of the same index: response sees the old entry.
        step(0, 0, 0, '0, 0, 1, 9, 20'h00055);
        step(0, 1, 9, 20'h00055, 1, 0, 0, '0);
        step(0, 0, 0, '0, 0, 1, 9, 20'h00055);
        idle();
    endtask

    task automatic test_wr_priority();
        logic [TW-1:0] t = 20'($urandom);
        step(0, 1, 7, t, 1, 1, 7, t);
        step(0, 0, 0, '0, 0, 1, 7, t);
        idle();
    endtask

    task automatic test_back_to_back();
        int            seen0;
        logic [TW-1:0] t;
        for (int i = 1; i <= 4; i++) step(0, 1, i, 20'($urandom), 1'($urandom_range(0, 3) != 0),
                                          0, 0, '0);
        seen0 = rsp_seen;
        for (int i = 1; i <= 4; i++) begin
            t = ($urandom_range(0, 1) == 0) ? ref_tag[i] : (ref_tag[i] ^ 20'h1);
            step(0, 0, 0, '0, 0, 1, i, t);
        end
        idle();
        idle();
        checks++;
        if (rsp_seen - seen0 != 4) begin
            failures++;
            $display("FAIL b2b_count: got %0d responses want 4", rsp_seen - seen0);
        end
    endtask

    task automatic test_flush();
        step(0, 1, 5, 20'h1A2, 1, 0, 0, '0);
        step(0, 0, 0, '0, 0, 1, 5, 20'h1A2);
        step(1, 0, 0, '0, 0, 1, 6, '0);
        run_walk("flush_walk", 100);
        step(0, 0, 0, '0, 0, 1, 5, 20'h1A2);
        idle();
    endtask

    task automatic test_reset_mid_walk();
        step(1, 0, 0, '0, 0, 0, 0, '0);
        repeat (50) @(posedge clk);
        #3;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({busy_o, flush_done_o, ready_o, rsp_valid_o, wr_gnt_o, ts_en_o, ts_we_o} !== 7'b0) begin
            failures++;
            $display("FAIL reset_mid_walk: busy=%b done=%b ready=%b rv=%b gnt=%b en=%b we=%b want 0",
                     busy_o, flush_done_o, ready_o, rsp_valid_o, wr_gnt_o, ts_en_o, ts_we_o);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        run_walk("reset_walk", -1);
    endtask

    task automatic test_random();
        logic [TW-1:0] base = 20'($urandom);
        for (int n = 0; n < 300; n++) begin
            step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 7), base + 20'($urandom_range(0, 1)),
                 1'($urandom_range(0, 4) != 0),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 7), base + 20'($urandom_range(0, 1)));
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        checks = 0; failures = 0; rsp_seen = 0;
        test_reset();
        test_init_walk();
        test_write_hit();
        test_wr_priority();
        test_back_to_back();
        test_flush();
        test_reset_mid_walk();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
